// File: rtl/gtp_link_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gtp_link_pkg
// Description : Shared definitions for the channel-to-main GTP link. Both the
//               channel-side send arbiter and the main-side receive parser
//               import this package so that the word formats cannot drift.
// Revision    : 1.0 - initial release
// ============================================================================
package gtp_link_pkg;

  // K-character code points carried with gtp_kchar=1
  localparam logic [15:0] CH_COMMA = 16'h00BC;  // K28.5 idle/alignment
  localparam logic [15:0] CH_TRIG  = 16'h801C;  // K28.0 trigger

  // Block header layout: flag bit marks a header, low field is payload length
  localparam int HDR_FLAG_BIT = 15;
  localparam int HDR_LEN_MSB  = 8;
  localparam int HDR_LEN_LSB  = 0;
  localparam int HDR_LEN_W    = HDR_LEN_MSB - HDR_LEN_LSB + 1;

  // Receive framing state machine
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_SKIP    = 2'd2
  } rx_state_e;

  // Payload length carried by a header word
  function automatic logic [HDR_LEN_W-1:0] hdr_len(input logic [15:0] word);
    return word[HDR_LEN_MSB:HDR_LEN_LSB];
  endfunction

endpackage
`default_nettype wire

// File: rtl/gtp_rcv_parse_dpram.sv
`default_nettype none
// ============================================================================
// Module      : rcv_dpram
// Description : Simple dual-port RAM, one write port and one registered read
//               port, 2^ABITS x DW. Written for block-RAM inference.
// Revision    : 1.0 - initial release
// ============================================================================
module rcv_dpram #(
  parameter int ABITS = 12,
  parameter int DW    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [ABITS-1:0] waddr,
  input  logic [DW-1:0]    wdata,
  input  logic             re,
  input  logic [ABITS-1:0] raddr,
  output logic [DW-1:0]    rdata
);

  logic [DW-1:0] r_mem [2**ABITS];

  // Write port: array itself carries no reset so it maps onto block RAM
  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
  end

  // Registered read port; holds its value between accepted reads
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= r_mem[raddr];
  end

endmodule
`default_nettype wire

// File: rtl/gtp_rcv_parse.sv
`default_nettype none
// ============================================================================
// Module      : gtp_rcv_parse
// Description : Receive-side parser for the channel-to-main GTP link.
//               Regenerates trigger pulses from K28.0 words, re-frames data
//               blocks and buffers them in a circular RAM. A block becomes
//               readable only once its last word has been written.
// Revision    : 1.0 - initial release
// ============================================================================
module gtp_rcv_parse
  import gtp_link_pkg::*;
#(
  parameter int ABITS = 12
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [15:0]    gtp_data,
  input  logic           gtp_kchar,
  output logic           trig,
  input  logic           rd_en,
  output logic [15:0]    rd_data,
  output logic           rd_empty,
  output logic [ABITS:0] words_avail,
  output logic [15:0]    err_cnt,
  output logic [15:0]    ovf_cnt
);

  localparam logic [ABITS:0] c_DEPTH = {1'b1, {ABITS{1'b0}}};

  // Input stage S1
  logic [15:0]          r_s1_data;
  logic                 r_s1_k;

  // Framing state and pointers (ABITS+1 bits, wrap naturally)
  rx_state_e            r_state, w_state_nxt;
  logic [ABITS:0]       r_wr_ptr, w_wr_ptr_nxt;
  logic [ABITS:0]       r_cm_ptr, w_cm_ptr_nxt;
  logic [ABITS:0]       r_rd_ptr;
  logic [HDR_LEN_W-1:0] r_cnt, w_cnt_nxt;
  logic                 r_trig;
  logic [15:0]          r_err_cnt, r_ovf_cnt;

  // Decoded view of the S1 word
  logic                 w_is_comma, w_is_trig, w_is_kerr, w_is_data, w_is_hdr;
  logic [HDR_LEN_W-1:0] w_len;
  logic [ABITS:0]       w_used, w_free;
  logic [31:0]          w_free32, w_need32;
  logic                 w_fits;
  logic                 w_we, w_err_inc, w_ovf_inc, w_rd_acc;

  assign w_is_comma = r_s1_k && (r_s1_data == CH_COMMA);
  assign w_is_trig  = r_s1_k && (r_s1_data == CH_TRIG);
  assign w_is_kerr  = r_s1_k && !w_is_comma && !w_is_trig;
  assign w_is_data  = !r_s1_k;
  assign w_is_hdr   = r_s1_data[HDR_FLAG_BIT];
  assign w_len      = hdr_len(r_s1_data);

  // Space left in the ring, counting uncommitted words of an open block
  assign w_used   = r_wr_ptr - r_rd_ptr;
  assign w_free   = c_DEPTH - w_used;
  assign w_free32 = 32'(w_free);
  assign w_need32 = 32'(w_len) + 32'd1;
  assign w_fits   = (w_free32 >= w_need32);

  assign rd_empty    = (r_cm_ptr == r_rd_ptr);
  assign words_avail = r_cm_ptr - r_rd_ptr;
  assign w_rd_acc    = rd_en && !rd_empty;
  assign trig        = r_trig;
  assign err_cnt     = r_err_cnt;
  assign ovf_cnt     = r_ovf_cnt;

  // Register the incoming word; reset loads a comma so S1 decodes as idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_data <= CH_COMMA;
      r_s1_k    <= 1'b1;
    end else begin
      r_s1_data <= gtp_data;
      r_s1_k    <= gtp_kchar;
    end
  end

  // State, pointer, counter and trigger registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_wr_ptr  <= '0;
      r_cm_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_cnt     <= '0;
      r_trig    <= 1'b0;
      r_err_cnt <= '0;
      r_ovf_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_wr_ptr <= w_wr_ptr_nxt;
      r_cm_ptr <= w_cm_ptr_nxt;
      r_cnt    <= w_cnt_nxt;
      r_trig   <= w_is_trig;
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_err_inc && (r_err_cnt != 16'hFFFF)) r_err_cnt <= r_err_cnt + 16'd1;
      if (w_ovf_inc && (r_ovf_cnt != 16'hFFFF)) r_ovf_cnt <= r_ovf_cnt + 16'd1;
    end
  end

  // Framing decisions on the S1 word: next state, RAM write, commit, abort
  always_comb begin
    w_state_nxt  = r_state;
    w_wr_ptr_nxt = r_wr_ptr;
    w_cm_ptr_nxt = r_cm_ptr;
    w_cnt_nxt    = r_cnt;
    w_we         = 1'b0;
    w_err_inc    = 1'b0;
    w_ovf_inc    = 1'b0;
    if (w_is_kerr) begin
      // Unknown K-char: count it; an open block is rolled back to last commit
      w_err_inc = 1'b1;
      if (r_state == ST_PAYLOAD) begin
        w_wr_ptr_nxt = r_cm_ptr;
        w_state_nxt  = ST_IDLE;
      end
    end else if (w_is_data) begin
      case (r_state)
        ST_IDLE: begin
          if (!w_is_hdr) begin
            w_err_inc = 1'b1;
          end else if (w_fits) begin
            w_we         = 1'b1;
            w_wr_ptr_nxt = r_wr_ptr + 1'b1;
            if (w_len == '0) begin
              w_cm_ptr_nxt = r_wr_ptr + 1'b1;
            end else begin
              w_cnt_nxt   = w_len;
              w_state_nxt = ST_PAYLOAD;
            end
          end else begin
            w_ovf_inc = 1'b1;
            if (w_len != '0) begin
              w_cnt_nxt   = w_len;
              w_state_nxt = ST_SKIP;
            end
          end
        end
        ST_PAYLOAD: begin
          w_we         = 1'b1;
          w_wr_ptr_nxt = r_wr_ptr + 1'b1;
          w_cnt_nxt    = r_cnt - 1'b1;
          if (r_cnt == HDR_LEN_W'(1)) begin
            w_cm_ptr_nxt = r_wr_ptr + 1'b1;
            w_state_nxt  = ST_IDLE;
          end
        end
        ST_SKIP: begin
          w_cnt_nxt = r_cnt - 1'b1;
          if (r_cnt == HDR_LEN_W'(1)) w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  rcv_dpram #(
    .ABITS (ABITS),
    .DW    (16)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (w_we),
    .waddr (r_wr_ptr[ABITS-1:0]),
    .wdata (r_s1_data),
    .re    (w_rd_acc),
    .raddr (r_rd_ptr[ABITS-1:0]),
    .rdata (rd_data)
  );

endmodule
`default_nettype wire

// File: tb/tb_gtp_rcv_parse.sv
`default_nettype none
// ============================================================================
// Module      : tb_gtp_rcv_parse
// Description : Directed self-checking bench for gtp_rcv_parse (16-word ring).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gtp_rcv_parse;
  import gtp_link_pkg::*;

  localparam int ABITS = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [15:0]    gtp_data;
  logic           gtp_kchar;
  logic           trig;
  logic           rd_en;
  logic [15:0]    rd_data;
  logic           rd_empty;
  logic [ABITS:0] words_avail;
  logic [15:0]    err_cnt;
  logic [15:0]    ovf_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  gtp_rcv_parse #(.ABITS(ABITS)) dut (
    .clk         (clk),
    .rst         (rst),
    .gtp_data    (gtp_data),
    .gtp_kchar   (gtp_kchar),
    .trig        (trig),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .rd_empty    (rd_empty),
    .words_avail (words_avail),
    .err_cnt     (err_cnt),
    .ovf_cnt     (ovf_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one word for one clock, then fall back to commas
  task automatic put(input logic k, input logic [15:0] d);
    gtp_kchar = k;
    gtp_data  = d;
    tick();
    gtp_kchar = 1'b1;
    gtp_data  = CH_COMMA;
  endtask

  task automatic rd_chk(input string tag, input logic [15:0] exp);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk(tag, 32'(rd_data), 32'(exp));
  endtask

  logic [15:0] exp_q [$];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    rd_en     = 1'b0;
    gtp_kchar = 1'b1;
    gtp_data  = CH_COMMA;
    repeat (2) tick();
    chk("rst_trig",     32'(trig), 32'd0);
    chk("rst_rd_data",  32'(rd_data), 32'd0);
    chk("rst_empty",    32'(rd_empty), 32'd1);
    chk("rst_avail",    32'(words_avail), 32'd0);
    chk("rst_err",      32'(err_cnt), 32'd0);
    chk("rst_ovf",      32'(ovf_cnt), 32'd0);
    rst = 1'b0;
    tick();

    // Basic block with commas interleaved
    put(1'b1, CH_COMMA);
    put(1'b0, 16'h8003);
    put(1'b0, 16'hA000);
    put(1'b1, CH_COMMA);
    put(1'b0, 16'hA001);
    put(1'b0, 16'hA002);
    chk("blk1_empty_1clk", 32'(rd_empty), 32'd1);
    tick();
    chk("blk1_empty_2clk", 32'(rd_empty), 32'd0);
    chk("blk1_avail",      32'(words_avail), 32'd4);
    rd_chk("blk1_rd0", 16'h8003);
    rd_chk("blk1_rd1", 16'hA000);
    rd_chk("blk1_rd2", 16'hA001);
    rd_chk("blk1_rd3", 16'hA002);
    chk("blk1_avail_end", 32'(words_avail), 32'd0);
    chk("blk1_empty_end", 32'(rd_empty), 32'd1);
    rd_chk("blk1_rd_hold", 16'hA002);

    // Trigger injected mid-block
    put(1'b0, 16'h8003);
    put(1'b0, 16'hB000);
    put(1'b0, 16'hB001);
    put(1'b1, CH_TRIG);
    chk("trig_early", 32'(trig), 32'd0);
    put(1'b0, 16'hB002);
    chk("trig_pulse", 32'(trig), 32'd1);
    tick();
    chk("trig_end",    32'(trig), 32'd0);
    chk("trig_avail",  32'(words_avail), 32'd4);
    rd_chk("trig_rd0", 16'h8003);
    rd_chk("trig_rd1", 16'hB000);
    rd_chk("trig_rd2", 16'hB001);
    rd_chk("trig_rd3", 16'hB002);

    // Back-to-back triggers
    put(1'b1, CH_TRIG);
    chk("b2b_t0", 32'(trig), 32'd0);
    put(1'b1, CH_TRIG);
    chk("b2b_t1", 32'(trig), 32'd1);
    tick();
    chk("b2b_t2", 32'(trig), 32'd1);
    tick();
    chk("b2b_t3", 32'(trig), 32'd0);

    // Unknown K-char aborts the open block
    put(1'b0, 16'h8003);
    put(1'b0, 16'hC000);
    put(1'b1, 16'h80FC);
    repeat (2) tick();
    chk("abort_err",   32'(err_cnt), 32'd1);
    chk("abort_empty", 32'(rd_empty), 32'd1);
    chk("abort_avail", 32'(words_avail), 32'd0);
    put(1'b0, 16'h8001);
    put(1'b0, 16'hC111);
    tick();
    chk("abort_next_avail", 32'(words_avail), 32'd2);
    rd_chk("abort_rd0", 16'h8001);
    rd_chk("abort_rd1", 16'hC111);

    // Stray data word in IDLE
    put(1'b0, 16'h1234);
    tick();
    chk("stray_err",   32'(err_cnt), 32'd2);
    chk("stray_empty", 32'(rd_empty), 32'd1);

    // Overflow: 12 words committed, N=7 header cannot fit in the 4 left
    exp_q.delete();
    put(1'b0, 16'h800B);
    exp_q.push_back(16'h800B);
    for (int i = 0; i < 11; i++) begin
      put(1'b0, 16'hE000 + 16'(i));
      exp_q.push_back(16'hE000 + 16'(i));
    end
    tick();
    chk("ovf_fill_avail", 32'(words_avail), 32'd12);
    put(1'b0, 16'h8007);
    for (int i = 0; i < 7; i++) put(1'b0, 16'h8100 + 16'(i));
    put(1'b0, 16'h8002);
    put(1'b0, 16'hE100);
    put(1'b0, 16'hE101);
    exp_q.push_back(16'h8002);
    exp_q.push_back(16'hE100);
    exp_q.push_back(16'hE101);
    tick();
    chk("ovf_cnt",   32'(ovf_cnt), 32'd1);
    chk("ovf_avail", 32'(words_avail), 32'd15);
    chk("ovf_err",   32'(err_cnt), 32'd2);
    for (int i = 0; i < 15; i++) rd_chk($sformatf("ovf_rd%0d", i), exp_q[i]);
    chk("ovf_empty_end", 32'(rd_empty), 32'd1);

    // Asynchronous reset mid-payload with committed data present
    put(1'b0, 16'h8000);
    tick();
    chk("pre_rst_avail", 32'(words_avail), 32'd1);
    put(1'b0, 16'h8003);
    put(1'b0, 16'hF001);
    put(1'b1, CH_TRIG);
    put(1'b0, 16'hF002);
    chk("pre_rst_trig", 32'(trig), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_trig",    32'(trig), 32'd0);
    chk("arst_rd_data", 32'(rd_data), 32'd0);
    chk("arst_empty",   32'(rd_empty), 32'd1);
    chk("arst_avail",   32'(words_avail), 32'd0);
    chk("arst_err",     32'(err_cnt), 32'd0);
    chk("arst_ovf",     32'(ovf_cnt), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    put(1'b0, 16'h8001);
    put(1'b0, 16'hF0AA);
    tick();
    chk("post_rst_avail", 32'(words_avail), 32'd2);
    rd_chk("post_rst_rd0", 16'h8001);
    rd_chk("post_rst_rd1", 16'hF0AA);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
